vproc_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one memory-mapped slave bus between NUM_MASTERS VProc bus masters.
- Masters are VProc node instances with the burst interface enabled.
- Grants one master at a time and holds the grant for a whole burst (Burst/BurstLast).
- Sits between the VProc instances and a single memory or peripheral model in the test harness.

---
 rtl/vproc_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_vproc_bus_arbiter.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vproc_bus_arbiter.sv
// Round-robin arbiter sharing one slave bus between NUM_MASTERS VProc burst masters.
// Optional watchdog release is built when VPROC_ARB_TIMEOUT_EN is defined.
module vproc_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int IDX_WIDTH      = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      Clk,
    input  logic                      nReset,
    input  logic [32*NUM_MASTERS-1:0] MAddr,
    input  logic [NUM_MASTERS-1:0]    MWE,
    input  logic [NUM_MASTERS-1:0]    MRD,
    input  logic [32*NUM_MASTERS-1:0] MDataOut,
    input  logic [12*NUM_MASTERS-1:0] MBurst,
    input  logic [NUM_MASTERS-1:0]    MBurstLast,
    output logic [31:0]               MDataIn,
    output logic [NUM_MASTERS-1:0]    MWRAck,
    output logic [NUM_MASTERS-1:0]    MRDAck,
    output logic [31:0]               Addr,
    output logic                      WE,
    output logic                      RD,
    output logic [31:0]               DataOut,
    input  logic [31:0]               DataIn,
    input  logic                      WRAck,
    input  logic                      RDAck,
    output logic [NUM_MASTERS-1:0]    Grant,
    output logic [IDX_WIDTH-1:0]      GrantIdx,
    output logic                      ArbTimeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state;
    logic [IDX_WIDTH-1:0]   last;
    logic [NUM_MASTERS-1:0] req;
    logic                   busy;
    logic                   next_found;
    logic [IDX_WIDTH-1:0]   next_idx;
    logic [31:0]            own_addr;
    logic [31:0]            own_data;
    logic                   own_we;
    logic                   own_rd;
    logic [11:0]            own_burst;
    logic                   own_last;
    logic                   hit;
    logic                   done;
    logic                   expired;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 16 ||
        IDX_WIDTH < $clog2(NUM_MASTERS) || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("vproc_bus_arbiter: unsupported parameter set");
    end

    assign req  = MWE | MRD;
    assign busy = (state == BUSY);

    // Search above the last owner first, then wrap from index 0.
    always_comb begin
        next_found = 1'b0;
        next_idx   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!next_found && req[i] && IDX_WIDTH'(i) > last) begin
                next_found = 1'b1;
                next_idx   = IDX_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!next_found && req[i]) begin
                next_found = 1'b1;
                next_idx   = IDX_WIDTH'(i);
            end
        end
    end

    always_comb begin
        own_addr  = '0;
        own_data  = '0;
        own_we    = 1'b0;
        own_rd    = 1'b0;
        own_burst = '0;
        own_last  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (IDX_WIDTH'(i) == GrantIdx) begin
                own_addr  = MAddr[32*i +: 32];
                own_data  = MDataOut[32*i +: 32];
                own_we    = MWE[i];
                own_rd    = MRD[i];
                own_burst = MBurst[12*i +: 12];
                own_last  = MBurstLast[i];
            end
        end
    end

    assign Addr    = busy ? own_addr : '0;
    assign DataOut = busy ? own_data : '0;
    assign WE      = busy & own_we;
    assign RD      = busy & own_rd;
    assign MDataIn = DataIn;
    assign MWRAck  = Grant & {NUM_MASTERS{busy & WRAck}};
    assign MRDAck  = Grant & {NUM_MASTERS{busy & RDAck}};

    assign hit  = busy & ((own_we & WRAck) | (own_rd & RDAck));
    assign done = hit & ((own_burst <= 12'd1) | own_last);

`ifdef VPROC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] wd_cnt;
    logic             wd_flag;

    assign expired    = busy & ~hit & (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign ArbTimeout = wd_flag;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            wd_cnt  <= '0;
            wd_flag <= 1'b0;
        end else begin
            if (!busy || hit || expired) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (expired) begin
                wd_flag <= 1'b1;
            end
        end
    end
`else
    assign expired    = 1'b0;
    assign ArbTimeout = 1'b0;
`endif

    // Release never re-arbitrates: the owner's strobes are stale at that edge.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            Grant    <= '0;
            GrantIdx <= '0;
            last     <= IDX_WIDTH'(NUM_MASTERS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (next_found) begin
                        state    <= BUSY;
                        Grant    <= NUM_MASTERS'(1) << next_idx;
                        GrantIdx <= next_idx;
                        last     <= next_idx;
                    end
                end
                BUSY: begin
                    if (done || expired) begin
                        state <= IDLE;
                        Grant <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vproc_bus_arbiter.sv
// Scoreboard bench for vproc_bus_arbiter: expected grant tenures queued, checked as they occur.
// Define VPROC_ARB_TIMEOUT_EN to build the watchdog scenario with a 16-cycle limit.
module tb_vproc_bus_arbiter;

    localparam int N = 4;
`ifdef VPROC_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic            Clk = 1'b0;
    logic            nReset;
    logic [32*N-1:0] MAddr;
    logic [N-1:0]    MWE;
    logic [N-1:0]    MRD;
    logic [32*N-1:0] MDataOut;
    logic [12*N-1:0] MBurst;
    logic [N-1:0]    MBurstLast;
    logic [31:0]     MDataIn;
    logic [N-1:0]    MWRAck;
    logic [N-1:0]    MRDAck;
    logic [31:0]     Addr;
    logic            WE;
    logic            RD;
    logic [31:0]     DataOut;
    logic [31:0]     DataIn;
    logic            WRAck;
    logic            RDAck;
    logic [N-1:0]    Grant;
    logic [1:0]      GrantIdx;
    logic            ArbTimeout;

    vproc_bus_arbiter #(
        .NUM_MASTERS(N),
        .IDX_WIDTH(2),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clk(Clk),
        .nReset(nReset),
        .MAddr(MAddr),
        .MWE(MWE),
        .MRD(MRD),
        .MDataOut(MDataOut),
        .MBurst(MBurst),
        .MBurstLast(MBurstLast),
        .MDataIn(MDataIn),
        .MWRAck(MWRAck),
        .MRDAck(MRDAck),
        .Addr(Addr),
        .WE(WE),
        .RD(RD),
        .DataOut(DataOut),
        .DataIn(DataIn),
        .WRAck(WRAck),
        .RDAck(RDAck),
        .Grant(Grant),
        .GrantIdx(GrantIdx),
        .ArbTimeout(ArbTimeout)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int idx;
        int beats;
    } tenure_t;

    tenure_t     exp_q[$];
    int          txn[N];
    int          blen[N];
    int          beats[N];
    int          start[N];
    bit          wr[N];
    logic [31:0] base[N];
    logic [31:0] dbase[N];
    logic [11:0] single_burst;
    int          ack_delay;
    int          cyc;
    int          n_vec;
    int          n_err;

    function automatic logic [31:0] beat_addr(int i);
        return base[i] + 32'(4 * (blen[i] - beats[i]));
    endfunction

    function automatic logic [31:0] beat_data(int i);
        return dbase[i] + 32'(blen[i] - beats[i]);
    endfunction

    task automatic idle_inputs();
        MAddr      = '0;
        MDataOut   = '0;
        MWE        = '0;
        MRD        = '0;
        MBurst     = '0;
        MBurstLast = '0;
        DataIn     = '0;
        WRAck      = 1'b0;
        RDAck      = 1'b0;
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < N; i++) begin
            txn[i]   = 0;
            blen[i]  = 1;
            beats[i] = 1;
            start[i] = 1;
            wr[i]    = 1'b0;
            base[i]  = 32'(32'h1000 * (i + 1));
            dbase[i] = 32'hA000_0000 + 32'(i << 24);
        end
        single_burst = 12'd1;
        ack_delay    = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        idle_inputs();
        clear_cfg();
        repeat (2) @(posedge Clk);
        #3 nReset = 1'b1;
    endtask

    task automatic drive_master(int i);
        bit act;
        act = (txn[i] > 0) && (cyc >= start[i]);
        MWE[i]              = act && wr[i];
        MRD[i]              = act && !wr[i];
        MAddr[32*i +: 32]   = act ? beat_addr(i) : '0;
        MDataOut[32*i +: 32] = act ? beat_data(i) : '0;
        MBurst[12*i +: 12]  = (blen[i] == 1) ? single_burst : 12'(blen[i]);
        MBurstLast[i]       = act && (blen[i] > 1) && (beats[i] == 1);
    endtask

    // Master and slave models; grant tenures are popped from exp_q as they start.
    task automatic run(int budget);
        bit          own = 1'b0;
        bit          first = 1'b1;
        bit          fin = 1'b0;
        int          idle = 0;
        int          acks = 0;
        int          waited = 0;
        int          first_start = 1 << 30;
        logic [N-1:0] acked = '0;
        logic [N-1:0] prev_grant = '0;
        logic [N-1:0] exp_w;
        logic [N-1:0] exp_r;
        tenure_t     cur = '{idx: 0, beats: 0};
        for (int i = 0; i < N; i++) begin
            beats[i] = blen[i];
            if (txn[i] > 0 && start[i] < first_start) first_start = start[i];
        end
        cyc = 0;
        for (int c = 0; c < budget && !fin; c++) begin
            @(posedge Clk);
            #1;
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (acked[i]) begin
                    beats[i]--;
                    waited = 0;
                    if (beats[i] == 0) begin
                        txn[i]--;
                        beats[i] = blen[i];
                    end
                end
            end
            for (int i = 0; i < N; i++) drive_master(i);
            if (Grant != '0 && prev_grant == '0) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL grant_order: Grant=%b, none expected", Grant);
                end else begin
                    cur = exp_q.pop_front();
                    if (Grant !== 4'(1 << cur.idx) || GrantIdx !== 2'(cur.idx)) begin
                        n_err++;
                        $display("FAIL grant_order: Grant=%b idx=%0d, want master %0d",
                                 Grant, GrantIdx, cur.idx);
                    end
                end
                n_vec++;
                if (first && cyc != first_start + 1) begin
                    n_err++;
                    $display("FAIL grant_latency: cycle %0d, want %0d", cyc, first_start + 1);
                end else if (!first && idle != 1) begin
                    n_err++;
                    $display("FAIL grant_gap: %0d idle cycles, want 1", idle);
                end
                first  = 1'b0;
                own    = 1'b1;
                acks   = 0;
                waited = 0;
            end else if (prev_grant != '0 && Grant !== prev_grant) begin
                n_vec++;
                if (Grant !== '0 || acks != cur.beats) begin
                    n_err++;
                    $display("FAIL release: Grant=%b after %0d acks, want 0 after %0d",
                             Grant, acks, cur.beats);
                end
                own = 1'b0;
            end
            idle = (Grant == '0) ? idle + 1 : 0;
            if (own) waited++;
            #1;
            WRAck  = WE && own && (waited > ack_delay);
            RDAck  = RD && own && (waited > ack_delay);
            DataIn = $urandom;
            #1;
            exp_w = '0;
            exp_r = '0;
            if (own && WRAck) exp_w[cur.idx] = 1'b1;
            if (own && RDAck) exp_r[cur.idx] = 1'b1;
            n_vec++;
            if (MWRAck !== exp_w || MRDAck !== exp_r || MDataIn !== DataIn) begin
                n_err++;
                $display("FAIL ack_route: wr=%b rd=%b din=%h, want wr=%b rd=%b din=%h",
                         MWRAck, MRDAck, MDataIn, exp_w, exp_r, DataIn);
            end
            if (own && (WRAck || RDAck)) begin
                n_vec++;
                if (Addr !== beat_addr(cur.idx) || WE !== wr[cur.idx] ||
                    RD !== !wr[cur.idx] ||
                    (wr[cur.idx] && DataOut !== beat_data(cur.idx))) begin
                    n_err++;
                    $display("FAIL slave_beat: addr=%h data=%h we=%b rd=%b, want addr=%h data=%h",
                             Addr, DataOut, WE, RD, beat_addr(cur.idx), beat_data(cur.idx));
                end
                acks++;
            end
            acked      = exp_w | exp_r;
            prev_grant = Grant;
            fin = (Grant == '0) && !own && (exp_q.size() == 0) &&
                  (txn[0] == 0) && (txn[1] == 0) && (txn[2] == 0) && (txn[3] == 0);
        end
        if (!fin) begin
            n_vec++;
            n_err++;
            $display("FAIL run_budget: scenario incomplete after %0d cycles, %0d grants pending",
                     budget, exp_q.size());
        end
        WRAck = 1'b0;
        RDAck = 1'b0;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        idle_inputs();
        clear_cfg();
        MWE      = '1;
        MRD      = '1;
        MAddr    = '1;
        MDataOut = '1;
        WRAck    = 1'b1;
        RDAck    = 1'b1;
        DataIn   = 32'h1234_5678;
        @(posedge Clk);
        #1;
        n_vec++;
        if (Grant !== '0 || GrantIdx !== '0 || ArbTimeout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_regs: Grant=%b idx=%0d to=%b, want 0", Grant, GrantIdx, ArbTimeout);
        end
        n_vec++;
        if (Addr !== '0 || WE !== 1'b0 || RD !== 1'b0 || DataOut !== '0) begin
            n_err++;
            $display("FAIL reset_slave: addr=%h we=%b rd=%b data=%h, want 0", Addr, WE, RD, DataOut);
        end
        n_vec++;
        if (MWRAck !== '0 || MRDAck !== '0 || MDataIn !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL reset_acks: wr=%b rd=%b din=%h, want 0 0 12345678", MWRAck, MRDAck, MDataIn);
        end
        WRAck  = 1'b0;
        RDAck  = 1'b0;
        nReset = 1'b1;
        @(posedge Clk);
        #1;
        n_vec++;
        if (Grant !== 4'b0001 || GrantIdx !== 2'd0) begin
            n_err++;
            $display("FAIL reset_priority: Grant=%b idx=%0d, want 0001 idx 0", Grant, GrantIdx);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        txn[1]    = 1;
        wr[1]     = 1'b1;
        base[1]   = 32'h0000_0100;
        dbase[1]  = 32'hDEAD_BEEF;
        ack_delay = 2;
        exp_q.push_back('{idx: 1, beats: 1});
        run(30);
    endtask

    task automatic test_two_readers();
        do_reset();
        txn[0]       = 1;
        txn[2]       = 1;
        single_burst = 12'd0;
        exp_q.push_back('{idx: 0, beats: 1});
        exp_q.push_back('{idx: 2, beats: 1});
        run(30);
    endtask

    task automatic test_all_masters();
        do_reset();
        for (int i = 0; i < N; i++) begin
            txn[i] = 2;
            wr[i]  = (i % 2 == 1);
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) exp_q.push_back('{idx: i, beats: 1});
        end
        run(60);
    endtask

    task automatic test_burst_hold();
        do_reset();
        txn[2]   = 1;
        blen[2]  = 4;
        wr[2]    = 1'b1;
        txn[0]   = 1;
        wr[0]    = 1'b1;
        start[0] = 3;
        exp_q.push_back('{idx: 2, beats: 4});
        exp_q.push_back('{idx: 0, beats: 1});
        run(40);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        @(posedge Clk);
        #1;
        MWE[2]           = 1'b1;
        MAddr[95:64]     = 32'h0000_0300;
        MDataOut[95:64]  = 32'h0000_1111;
        MBurst[35:24]    = 12'd4;
        @(posedge Clk);
        #1;
        n_vec++;
        if (Grant !== 4'b0100) begin
            n_err++;
            $display("FAIL midburst_grant: Grant=%b, want 0100", Grant);
        end
        WRAck = 1'b1;
        @(posedge Clk);
        #1;
        MAddr[95:64]    = 32'h0000_0304;
        MDataOut[95:64] = 32'h0000_2222;
        #1;
        n_vec++;
        if (Grant !== 4'b0100 || MWRAck !== 4'b0100 || WE !== 1'b1) begin
            n_err++;
            $display("FAIL midburst_beat2: Grant=%b ack=%b we=%b, want 0100 0100 1", Grant, MWRAck, WE);
        end
        nReset = 1'b0;
        #1;
        n_vec++;
        if (Grant !== '0 || GrantIdx !== '0 || WE !== 1'b0 || RD !== 1'b0 ||
            MWRAck !== '0 || MRDAck !== '0 || Addr !== '0) begin
            n_err++;
            $display("FAIL midburst_reset: Grant=%b we=%b rd=%b ack=%b addr=%h, want all 0",
                     Grant, WE, RD, MWRAck, Addr);
        end
        idle_inputs();
        clear_cfg();
        @(posedge Clk);
        #3 nReset = 1'b1;
        txn[0] = 1;
        txn[3] = 1;
        wr[0]  = 1'b1;
        exp_q.push_back('{idx: 0, beats: 1});
        exp_q.push_back('{idx: 3, beats: 1});
        run(30);
        do_reset();
        txn[3] = 1;
        exp_q.push_back('{idx: 3, beats: 1});
        run(30);
    endtask

    task automatic test_timeout();
        int held;
        do_reset();
        @(posedge Clk);
        #1;
        MRD[1]          = 1'b1;
        MAddr[63:32]    = 32'h0000_2000;
        MBurst[23:12]   = 12'd1;
        @(posedge Clk);
        #1;
        MWE[2]          = 1'b1;
        MAddr[95:64]    = 32'h0000_3000;
        MDataOut[95:64] = 32'h0000_0077;
        MBurst[35:24]   = 12'd1;
        n_vec++;
        if (Grant !== 4'b0010 || ArbTimeout !== 1'b0) begin
            n_err++;
            $display("FAIL stall_grant: Grant=%b to=%b, want 0010 0", Grant, ArbTimeout);
        end
        held = 0;
        for (int c = 0; c < 40 && Grant == 4'b0010; c++) begin
            held++;
            @(posedge Clk);
            #1;
        end
`ifdef VPROC_ARB_TIMEOUT_EN
        n_vec++;
        if (held != 16 || Grant !== '0 || ArbTimeout !== 1'b1 || MRDAck !== '0) begin
            n_err++;
            $display("FAIL timeout_release: held %0d Grant=%b to=%b, want 16 0000 1",
                     held, Grant, ArbTimeout);
        end
        MRD[1] = 1'b0;
        @(posedge Clk);
        #1;
        n_vec++;
        if (Grant !== 4'b0100 || GrantIdx !== 2'd2) begin
            n_err++;
            $display("FAIL timeout_next: Grant=%b idx=%0d, want 0100 idx 2", Grant, GrantIdx);
        end
        WRAck = 1'b1;
        #1;
        n_vec++;
        if (MWRAck !== 4'b0100 || DataOut !== 32'h0000_0077) begin
            n_err++;
            $display("FAIL timeout_next_ack: ack=%b data=%h, want 0100 00000077", MWRAck, DataOut);
        end
        @(posedge Clk);
        #1;
        MWE[2] = 1'b0;
        WRAck  = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        n_vec++;
        if (Grant !== '0 || ArbTimeout !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_sticky: Grant=%b to=%b, want 0000 1", Grant, ArbTimeout);
        end
        nReset = 1'b0;
        #1;
        n_vec++;
        if (ArbTimeout !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_clear: to=%b, want 0", ArbTimeout);
        end
`else
        n_vec++;
        if (held != 40 || Grant !== 4'b0010 || ArbTimeout !== 1'b0) begin
            n_err++;
            $display("FAIL hold_forever: held %0d Grant=%b to=%b, want 40 0010 0",
                     held, Grant, ArbTimeout);
        end
`endif
        do_reset();
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        cyc    = 0;
        nReset = 1'b0;
        idle_inputs();
        clear_cfg();
        test_reset();
        test_single_write();
        test_two_readers();
        test_all_masters();
        test_burst_hold();
        test_reset_mid_burst();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
